// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in serial-out transmitter.
package piso_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result    = result + 1;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/piso_shreg.sv
// Loadable WIDTH-bit shift register; o_bit is the bit currently being transmitted.
module piso_shreg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic             i_msb_first,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_bit
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_data;
    end else if (i_shift) begin
      if (i_msb_first) r_q <= {r_q[WIDTH-2:0], 1'b0};
      else             r_q <= {1'b0, r_q[WIDTH-1:1]};
    end
  end

  assign o_bit = i_msb_first ? r_q[WIDTH-1] : r_q[0];

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter with valid/ready load and back-to-back framing.
// Optional even parity bit per frame when PISO_SERIALIZER_PARITY_EN is defined.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_start,
  output logic             busy,
  output logic [1:0]       o_dbg_state
);

  localparam int CW = clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  // Handshake: a word moves when load_valid && load_ready at a rising edge.
  // load_ready depends only on rst, state and counter, never on load_valid.
  state_t        r_state, w_state_next;
  logic [CW-1:0] r_cnt, w_cnt_next;
  logic          w_accept;
  logic          w_last_bit;
  logic          w_frame_end;
  logic          w_load;
  logic          w_shift;
  logic          w_bit;

  assign w_last_bit = (r_state == SHIFT) && (r_cnt == LAST);
  assign w_accept   = load_valid && load_ready;

`ifdef PISO_SERIALIZER_PARITY_EN
  logic r_parity;
  assign w_frame_end = (r_state == PAR);

  always_ff @(posedge clk) begin
    if (rst)         r_parity <= 1'b0;
    else if (w_load) r_parity <= ^load_data;
  end
`else
  assign w_frame_end = w_last_bit;
`endif

  assign load_ready = !rst && ((r_state == IDLE) || w_frame_end);

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_load       = 1'b0;
    w_shift      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_next = SHIFT;
          w_cnt_next   = '0;
          w_load       = 1'b1;
        end
      end
      SHIFT: begin
        if (!w_last_bit) begin
          w_cnt_next = r_cnt + 1'b1;
          w_shift    = 1'b1;
        end else begin
`ifdef PISO_SERIALIZER_PARITY_EN
          w_state_next = PAR;
          w_cnt_next   = '0;
`else
          w_cnt_next   = '0;
          w_load       = w_accept;
          w_state_next = w_accept ? SHIFT : IDLE;
`endif
        end
      end
`ifdef PISO_SERIALIZER_PARITY_EN
      PAR: begin
        w_cnt_next   = '0;
        w_load       = w_accept;
        w_state_next = w_accept ? SHIFT : IDLE;
      end
`endif
      default: begin
        w_state_next = IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  piso_shreg #(
    .WIDTH(WIDTH)
  ) u_shreg (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_shift    (w_shift),
    .i_msb_first(MSB_FIRST != 0),
    .i_data     (load_data),
    .o_bit      (w_bit)
  );

  // Outputs come straight from registered state, so sout is forced low outside a frame.
  always_comb begin
    sout_valid  = (r_state == SHIFT) || (r_state == PAR);
    frame_start = (r_state == SHIFT) && (r_cnt == '0);
    busy        = (r_state != IDLE);
    sout        = 1'b0;
    if (r_state == SHIFT) sout = w_bit;
`ifdef PISO_SERIALIZER_PARITY_EN
    if (r_state == PAR)   sout = r_parity;
`endif
  end

  assign o_dbg_state = r_state;

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
Parallel-in, serial-out transmitter. It feeds the 4-stage serial shift chain and any downstream serial receiver.
- Accepts a WIDTH-bit word over a valid/ready handshake.
- Emits the word one bit per clk on sout, with a qualifying valid strobe and a start-of-frame marker.
- Supports back-to-back words with no idle gap.

Parameters:
WIDTH, 4, word width in bits; legal range 2..32.
MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  reset, synchronous, active-high.
load_valid  input  1  upstream has a word on load_data.
load_ready  output  1  block can accept a word this cycle.
load_data  input  WIDTH  parallel word; sampled only on handshake.
sout  output  1  serial data bit, registered.
sout_valid  output  1  sout carries a valid bit this cycle.
frame_start  output  1  high on the first bit of each word.
busy  output  1  a word is being shifted (state != IDLE).

Behaviour:
- Handshake: a word is accepted when load_valid && load_ready at a rising edge. load_data is ignored at all other times. load_valid may drop without acceptance; nothing is captured.
- State machine:
  - States: IDLE, SHIFT, PAR (PAR exists only with the optional feature).
  - IDLE: load_ready = 1. On acceptance, go to SHIFT, load the shift register, bit counter = 0.
  - SHIFT: each cycle present one bit and increment the counter. The last bit is cnt == WIDTH-1.
    - Last bit with acceptance: reload and stay in SHIFT (no gap).
    - Last bit without acceptance: go to IDLE.
    - Last bit with parity enabled: go to PAR.
  - PAR: present the parity bit for one cycle, then behave as the last-bit cycle above.
- load_ready = !rst && (IDLE, or the final bit cycle of a frame). It is combinational from state and counter; it never depends on load_valid.
- Latency: first bit appears on sout in the cycle after acceptance. Frame length is WIDTH cycles, or WIDTH+1 with parity.
- Bit order: MSB_FIRST=1 shifts left and sends the MSB first; MSB_FIRST=0 shifts right and sends the LSB first.
- Outputs:
  - sout_valid = 1 in every SHIFT/PAR cycle, 0 in IDLE.
  - frame_start = 1 only when cnt == 0 in SHIFT.
  - sout = 0 whenever sout_valid = 0.
- Reset (synchronous, rst high at an edge): next state IDLE, and sout, sout_valid, frame_start, busy, counter and shift register all become 0. load_ready is 0 while rst is high.
  - Reset mid-frame aborts the frame. No remaining bits are sent.
  - A handshake presented in the same cycle as rst is discarded.
- Counter width is clog2(WIDTH+1) and wraps only by explicit reload to 0. It never free-runs past WIDTH.

Optional Feature:
Macro: PISO_SERIALIZER_PARITY_EN.
- Defined:
  - Even parity (XOR of the captured word) is computed at load and sent as one extra bit after the data bits, in state PAR, with sout_valid = 1 and frame_start = 0.
  - load_ready is asserted during the PAR cycle instead of the last data bit.
- Not defined: PAR state, parity logic and register are absent. Frames are exactly WIDTH bits.

Decomposition:
- Shared package piso_pkg:
  - state enum: IDLE = 2'd0, SHIFT = 2'd1, PAR = 2'd2.
  - clog2 helper function.
  - default WIDTH constant (4).
- One natural sub-module, piso_shreg:
  - WIDTH-bit loadable shift register with load, shift and direction inputs, exposing the outgoing bit.
  - FSM and counter stay in the top module.

Test Plan:
- Reset, then load 4'b1011 held one cycle (WIDTH=4, MSB_FIRST=1) -> sout = 1,0,1,1 on cycles 1..4 after acceptance; frame_start only on cycle 1; then sout_valid = 0 and busy = 0.
- MSB_FIRST=0, load 4'b1011 -> sout = 1,1,0,1.
- load_valid held high with 4'hA then 4'h5 -> 8 consecutive valid bits 1,0,1,0,0,1,0,1; frame_start on bits 1 and 5; load_ready high only on the handshake-cycle boundaries.
- Assert rst on the 2nd bit of 4'hF -> next cycle sout_valid = 0, sout = 0, busy = 0, load_ready = 1 after rst drops; the next word 4'h3 is sent cleanly as 0,0,1,1.
- load_valid pulses while busy, not on the final bit (4'h6 presented mid-frame) -> ignored; the current frame is unchanged.
- With PISO_SERIALIZER_PARITY_EN, load 4'b0111 -> sout = 0,1,1,1 then parity 1; frame is 5 cycles; load_ready high only in the parity cycle.
